instr_encoder: RTL

//   Inverse of the control unit: packs a decoded micro-op (ALU code or branch select plus

---
 rtl/instr_encoder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Packs decoded micro-ops into 32-bit instruction words and queues them in a small FIFO.
// Illegal commands are accepted but dropped, raising a one-cycle err pulse.
module instr_encoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_kind,
  input  logic [5:0]       in_alu_control,
  input  logic [2:0]       in_br_sel,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [11:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             err,
  output logic [1:0]       err_kind,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FCNT_W = $clog2(DEPTH + 1);
  localparam logic [6:0]  OPC_R  = 7'b0110011;
  localparam logic [6:0]  OPC_I  = 7'b1001100;
  localparam logic [6:0]  OPC_B  = 7'b1010101;

  logic [31:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              err_q, err_d;
  logic [1:0]        err_kind_q, err_kind_d;
  logic [CNT_W-1:0]  icnt_q, icnt_d, ecnt_q, ecnt_d;

  logic [31:0] enc_word_c;
  logic        enc_legal_c;
  logic        accept_c, push_c, pop_c;

  // Combinational encoder shared by all command kinds
  always_comb begin
    enc_word_c  = '0;
    enc_legal_c = 1'b0;
    case (in_kind)
      2'b00: begin
        enc_word_c = {7'b0000000, in_rs2, in_rs1, in_alu_control[2:0], in_rd, OPC_R};
        if (in_alu_control[5:3] == 3'b000) begin
          enc_legal_c = 1'b1;
        end else if (in_alu_control == 6'b001000) begin
          enc_legal_c        = 1'b1;
          enc_word_c[31:25]  = 7'b0100000;
          enc_word_c[14:12]  = 3'b010;
        end else if (in_alu_control == 6'b001001) begin
          enc_legal_c        = 1'b1;
          enc_word_c[31:25]  = 7'b0100000;
          enc_word_c[14:12]  = 3'b011;
        end
      end
      2'b01: begin
        enc_word_c  = {in_imm, in_rs1, ~in_alu_control[2:0], in_rd, OPC_I};
        enc_legal_c = (in_alu_control[5:3] == 3'b111);
      end
      2'b10: begin
        enc_word_c  = {in_imm[11:5], in_rs2, in_rs1, in_br_sel, in_imm[4:0], OPC_B};
        enc_legal_c = (in_br_sel != 3'b111);
      end
      default: begin
        enc_word_c  = '0;
        enc_legal_c = 1'b0;
      end
    endcase
  end

  assign in_ready  = reset & ~flush & (fcnt_q < FCNT_W'(DEPTH));
  assign accept_c  = in_valid & in_ready;
  assign push_c    = accept_c & enc_legal_c;
  assign out_valid = (fcnt_q != '0);
  assign pop_c     = out_valid & out_ready & ~flush;

  // Next-state for pointers, occupancy, error tracking and counters
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fcnt_d     = fcnt_q;
    err_d      = 1'b0;
    err_kind_d = err_kind_q;
    icnt_d     = icnt_q;
    ecnt_d     = ecnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fcnt_d   = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_c && !pop_c)      fcnt_d = fcnt_q + FCNT_W'(1);
      else if (!push_c && pop_c) fcnt_d = fcnt_q - FCNT_W'(1);
    end
    if (push_c && (icnt_q != '1)) icnt_d = icnt_q + CNT_W'(1);
    if (accept_c && !enc_legal_c) begin
      err_d      = 1'b1;
      err_kind_d = in_kind;
      if (ecnt_q != '1) ecnt_d = ecnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
      err_q      <= 1'b0;
      err_kind_q <= '0;
      icnt_q     <= '0;
      ecnt_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
      err_q      <= err_d;
      err_kind_q <= err_kind_d;
      icnt_q     <= icnt_d;
      ecnt_q     <= ecnt_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= enc_word_c;
  end

  assign out_instr   = out_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign err         = err_q;
  assign err_kind    = err_kind_q;
  assign instr_count = icnt_q;
  assign err_count   = ecnt_q;

endmodule
